// File: rtl/i281_datamem_uart_dump.sv
// i281_datamem_uart_dump
// Snapshots the i281 CPU's data-memory observation bytes on request and
// sends them, byte 0 first, over an 8N1 UART transmit line (LSB first).
// Optional feature macro: I281_DUMP_CHECKSUM_EN appends a two's-complement
// checksum frame after the last data byte; byte_index widens to 5 bits so
// it can report the checksum frame as index NUM_BYTES.
module i281_datamem_uart_dump #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] datamem_bus,
  output logic         tx,
  output logic         busy,
  output logic         done,
`ifdef I281_DUMP_CHECKSUM_EN
  output logic [4:0]   byte_index
`else
  output logic [3:0]   byte_index
`endif
);

`ifdef I281_DUMP_CHECKSUM_EN
  localparam int IDX_W      = 5;
  localparam int LAST_FRAME = NUM_BYTES;
`else
  localparam int IDX_W      = 4;
  localparam int LAST_FRAME = NUM_BYTES - 1;
`endif

  localparam logic [15:0]      BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(LAST_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [IDX_W-1:0]   byte_index_q, byte_index_d;
  logic [127:0]       snapshot_q, snapshot_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [7:0]         cur_byte;
  logic [2:0]         next_bit;

`ifdef I281_DUMP_CHECKSUM_EN
  logic [7:0]         byte_sum;
  logic [7:0]         checksum;

  // Two's-complement checksum of the captured bytes, so host sum + checksum == 0 mod 256
  always_comb begin
    byte_sum = 8'd0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      byte_sum = byte_sum + snapshot_q[8*i +: 8];
    end
    checksum = 8'd0 - byte_sum;
  end
`endif

  // Select the byte of the frame in flight (checksum frame when enabled)
  always_comb begin
    next_bit = bit_q + 3'd1;
    cur_byte = snapshot_q[{byte_index_q[3:0], 3'b000} +: 8];
`ifdef I281_DUMP_CHECKSUM_EN
    if (byte_index_q == IDX_W'(NUM_BYTES)) begin
      cur_byte = checksum;
    end
`endif
  end

  // Next-state and registered-output logic; each bit is held CLKS_PER_BIT cycles
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    byte_index_d = byte_index_q;
    snapshot_d   = snapshot_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d         = 1'b1;
        busy_d       = 1'b0;
        byte_index_d = '0;
        if (start) begin
          snapshot_d = datamem_bus;
          state_d    = S_START_BIT;
          baud_d     = 16'd0;
          bit_d      = 3'd0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_START_BIT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
          state_d = S_DATA_BITS;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      S_DATA_BITS: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP_BIT;
          end else begin
            bit_d = next_bit;
            tx_d  = cur_byte[next_bit];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      S_STOP_BIT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = 16'd0;
          if (byte_index_q < LAST_INDEX) begin
            byte_index_d = byte_index_q + IDX_W'(1);
            tx_d         = 1'b0;
            state_d      = S_START_BIT;
          end else begin
            byte_index_d = '0;
            tx_d         = 1'b1;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            state_d      = S_DONE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      S_DONE: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the line idle-high immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      baud_q       <= 16'd0;
      bit_q        <= 3'd0;
      byte_index_q <= '0;
      snapshot_q   <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      byte_index_q <= byte_index_d;
      snapshot_q   <= snapshot_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign byte_index = byte_index_q;

endmodule

// File: tb/tb_i281_datamem_uart_dump.sv
// Testbench for i281_datamem_uart_dump (CLKS_PER_BIT=4, NUM_BYTES=16).
// Honours I281_DUMP_CHECKSUM_EN the same way as the design.
module tb_i281_datamem_uart_dump;

  localparam int CPB       = 4;
  localparam int NUM       = 16;
  localparam int FRAME_CYC = 10 * CPB;
`ifdef I281_DUMP_CHECKSUM_EN
  localparam int IDXW   = 5;
  localparam int FRAMES = NUM + 1;
`else
  localparam int IDXW   = 4;
  localparam int FRAMES = NUM;
`endif
  localparam int TOTAL = FRAMES * FRAME_CYC;

  logic            clock;
  logic            reset_n;
  logic            start;
  logic [127:0]    datamem_bus;
  logic            tx;
  logic            busy;
  logic            done;
  logic [IDXW-1:0] byte_index;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [127:0] data;
    bit           mutate;
    bit           busy_start;
    int           exp_busy;
  } vec_t;

  vec_t vecs[5];

  i281_datamem_uart_dump #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (NUM)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .datamem_bus(datamem_bus),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .byte_index (byte_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value with the bench's expectation
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: byte sent in frame f (data bytes, then checksum frame if enabled)
  function automatic logic [7:0] model_byte(input logic [127:0] d, input int f);
    int s;
    if (f < NUM) return d[8*f +: 8];
    s = 0;
    for (int i = 0; i < NUM; i++) s += int'(d[8*i +: 8]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  // Reference: expected tx level c cycles after the start-sampling edge
  function automatic logic model_tx(input logic [127:0] d, input int c);
    int f;
    int p;
    logic [7:0] b;
    if (c >= TOTAL) return 1'b1;
    f = c / FRAME_CYC;
    p = (c % FRAME_CYC) / CPB;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    b = model_byte(d, f);
    return b[p-1];
  endfunction

  // Run one complete dump and compare every cycle against the reference
  task automatic applyStimulus(input int id, input logic [127:0] data, input bit mutate,
                               input bit busy_start, input int exp_busy);
    logic [7:0] dec[FRAMES];
    logic       etx, ebusy, edone;
    int         eidx;
    int         tx_err, busy_err, done_err, idx_err, busy_cnt, done_cnt;
    tx_err = 0; busy_err = 0; done_err = 0; idx_err = 0; busy_cnt = 0; done_cnt = 0;
    for (int f = 0; f < FRAMES; f++) dec[f] = 8'h00;

    @(negedge clock);
    datamem_bus = data;
    start       = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c <= TOTAL + 1; c++) begin
      etx = model_tx(data, c);
      if (c < TOTAL) begin
        ebusy = 1'b1; edone = 1'b0; eidx = c / FRAME_CYC;
      end else if (c == TOTAL) begin
        ebusy = 1'b0; edone = 1'b1; eidx = 0;
      end else begin
        ebusy = 1'b0; edone = 1'b0; eidx = 0;
      end
      if (tx !== etx) tx_err++;
      if (busy !== ebusy) busy_err++;
      if (done !== edone) done_err++;
      if (int'(byte_index) != eidx) idx_err++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (c < TOTAL && (c % CPB) == 2) begin
        if (((c % FRAME_CYC) / CPB) >= 1 && ((c % FRAME_CYC) / CPB) <= 8)
          dec[c / FRAME_CYC][((c % FRAME_CYC) / CPB) - 1] = tx;
      end
      @(negedge clock);
      start = (busy_start && c == 5 * FRAME_CYC + 10) ? 1'b1 : 1'b0;
      if (mutate && c == 1) datamem_bus = '1;
      @(posedge clock); #1;
    end

    checkOutput($sformatf("v%0d_tx_wave_errors", id), tx_err, 0);
    checkOutput($sformatf("v%0d_busy_wave_errors", id), busy_err, 0);
    checkOutput($sformatf("v%0d_done_wave_errors", id), done_err, 0);
    checkOutput($sformatf("v%0d_index_wave_errors", id), idx_err, 0);
    checkOutput($sformatf("v%0d_busy_cycles", id), busy_cnt, exp_busy);
    checkOutput($sformatf("v%0d_done_pulses", id), done_cnt, 1);
    for (int f = 0; f < FRAMES; f++)
      checkOutput($sformatf("v%0d_frame%0d_byte", id, f), dec[f], model_byte(data, f));
  endtask

  initial begin
    logic [127:0] pat;
    logic [127:0] rnd;
    logic [7:0]   dec0;
    int           dcount;
    bit           found;

    tests_run    = 0;
    tests_failed = 0;
    start        = 1'b0;
    datamem_bus  = '0;
    reset_n      = 1'b1;

    for (int i = 0; i < 16; i++) pat[8*i +: 8] = 8'(8'h10 + i);

    // Reset held for three cycles, then released
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_index", byte_index, 0);
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("post_reset_tx", tx, 1);
    checkOutput("post_reset_busy", busy, 0);
    checkOutput("post_reset_done", done, 0);
    checkOutput("post_reset_index", byte_index, 0);

    // Mid-frame reset during byte 3, bit 4 (all-zero data so tx is low there)
    @(negedge clock);
    datamem_bus = '0;
    start       = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c < 3 * FRAME_CYC + 21; c++) begin
      @(negedge clock) start = 1'b0;
      @(posedge clock); #1;
    end
    checkOutput("midreset_pre_tx", tx, 0);
    checkOutput("midreset_pre_busy", busy, 1);
    checkOutput("midreset_pre_index", byte_index, 3);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset_async_tx", tx, 1);
    checkOutput("midreset_async_busy", busy, 0);
    dcount = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    @(negedge clock) reset_n = 1'b1;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    checkOutput("midreset_no_done_or_busy", dcount, 0);

    // Table of whole-dump vectors
    vecs[0] = '{data: pat,  mutate: 1'b0, busy_start: 1'b0, exp_busy: TOTAL};
    vecs[1] = '{data: pat,  mutate: 1'b1, busy_start: 1'b0, exp_busy: TOTAL};
    vecs[2] = '{data: pat,  mutate: 1'b0, busy_start: 1'b1, exp_busy: TOTAL};
    vecs[3] = '{data: {16{8'h01}}, mutate: 1'b0, busy_start: 1'b0, exp_busy: TOTAL};
    vecs[4] = '{data: {16{8'hA5}}, mutate: 1'b1, busy_start: 1'b1, exp_busy: TOTAL};
    for (int v = 0; v < 5; v++)
      applyStimulus(v, vecs[v].data, vecs[v].mutate, vecs[v].busy_start, vecs[v].exp_busy);

    // Randomised dumps checked against the reference
    for (int r = 0; r < 3; r++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(10 + r, rnd, r[0], 1'b0, TOTAL);
    end

    // Start held high: next dump begins in the idle cycle after done, with a fresh snapshot
    @(negedge clock);
    datamem_bus = pat;
    start       = 1'b1;
    found       = 1'b0;
    for (int k = 0; k < TOTAL + 20 && !found; k++) begin
      @(posedge clock); #1;
      if (done === 1'b1) found = 1'b1;
    end
    checkOutput("hold_done_seen", found, 1);
    @(negedge clock);
    datamem_bus        = '0;
    datamem_bus[7:0]   = 8'hC6;
    @(posedge clock); #1;
    checkOutput("hold_idle_tx", tx, 1);
    checkOutput("hold_idle_busy", busy, 0);
    checkOutput("hold_idle_done", done, 0);
    @(posedge clock); #1;
    checkOutput("hold_restart_tx", tx, 0);
    checkOutput("hold_restart_busy", busy, 1);
    checkOutput("hold_restart_index", byte_index, 0);
    dec0 = 8'h00;
    for (int c = 1; c <= 37; c++) begin
      @(posedge clock); #1;
      if (c >= 6 && c <= 34 && (c % CPB) == 2) dec0[(c - 6) / CPB] = tx;
    end
    checkOutput("hold_new_snapshot_byte0", dec0, 8'hC6);
    @(negedge clock);
    start   = 1'b0;
    reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(posedge clock);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i281_datamem_uart_dump.md
Name: i281_datamem_uart_dump

Overview:
- Read-side consumer of the i281 multicycle CPU's 16-byte data-memory observation outputs.
- On request, snapshots all 16 bytes and serialises them, address 0 first, over a UART TX line (8N1, LSB first).
- Lets a host dump program results after a run, without a logic analyser or seven-segment displays.
- Sits beside i281_toplevel; receives datamem0..datamem15 packed into one bus.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- NUM_BYTES, 16, bytes dumped per request; legal range 1..16; bytes 0..NUM_BYTES-1 are sent.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  dump request; sampled on rising edge while idle.
- datamem_bus  input  128  byte i = datamem_bus[8i+7:8i] = datamemi.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
- done  output  1  one-cycle pulse after the final stop bit.
- byte_index  output  4  index of the byte currently on tx; 0 when idle.

Behaviour:
- Reset (reset_n low, asynchronous): tx=1, busy=0, done=0, byte_index=0; bit counter, baud counter and snapshot cleared; FSM=IDLE. Release takes effect at the next clock edge.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, DONE.
- IDLE:
  - start=1 at edge E: capture the full datamem_bus into the snapshot register; byte_index=0.
  - After E: tx=0, busy=1, FSM=START_BIT.
  - CPU writes after E do not affect the dump; no tearing.
- Bit timing:
  - The baud counter counts 0..CLKS_PER_BIT-1; each bit is held exactly CLKS_PER_BIT cycles.
  - START_BIT holds tx=0, then goes to DATA_BITS.
  - DATA_BITS sends snapshot byte bits 0..7 (LSB first), then goes to STOP_BIT.
  - STOP_BIT holds tx=1 for one bit time.
- After STOP_BIT:
  - If byte_index < NUM_BYTES-1: increment byte_index and go directly to START_BIT. No idle gap between frames.
  - Otherwise go to DONE.
- DONE lasts one cycle: done=1, busy=0, tx=1, byte_index=0; then IDLE.
- Total dump length: NUM_BYTES*10*CLKS_PER_BIT cycles from the first tx low to done high.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: a new dump begins in the IDLE cycle after DONE, with a new snapshot.
- Reset asserted mid-frame: tx returns high immediately (asynchronous); partial frame abandoned; no done pulse.
- Registered outputs only; tx has no combinational path from inputs.

Optional Feature:
- Macro: I281_DUMP_CHECKSUM_EN.
- Defined:
  - After byte NUM_BYTES-1, one extra 8N1 frame is sent: the two's-complement checksum, (256 - sum of the dumped bytes mod 256) mod 256, computed from the snapshot.
  - byte_index reads NUM_BYTES during the checksum frame.
  - Dump length: (NUM_BYTES+1)*10*CLKS_PER_BIT cycles.
  - done follows the checksum stop bit.
- Undefined: no checksum frame; no checksum logic synthesised.

Test Plan (CLKS_PER_BIT=4, NUM_BYTES=16):
- Reset: hold reset_n=0 for 3 cycles, then release. Expect tx=1, busy=0, done=0, byte_index=0 during and after reset.
- Full dump: datamem i = 8'h10+i, 1-cycle start pulse. Expect:
  - 16 frames decoded as 10..1F, each bit 4 cycles wide, stop bits high.
  - busy high for exactly 640 cycles; done pulse on the next cycle.
- Snapshot: datamem_bus changes to all 8'hFF two cycles after start. Expect bytes still decoded as 10..1F.
- Busy start: pulse start during byte 5. Expect no restart, byte_index continues 5->6, one done pulse only.
- Mid-frame reset: drop reset_n during byte 3, bit 4. Expect tx=1 and busy=0 asynchronously, no done pulse. A later start dumps from byte 0.
- I281_DUMP_CHECKSUM_EN defined, all bytes 8'h01: expect a 17th frame of 8'hF0, busy high for 680 cycles, byte_index=16 during the checksum frame.
